// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory with bounded locked bursts.
// Build option DMEM_ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise port 0 wins every tie.

module dmem_arb_rport #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cap_i;
      if (cap_i) rdata_q <= mem_rd_i;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_LOCK      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p1_req,
  input  logic                     p0_we,
  input  logic                     p1_we,
  input  logic                     p0_lock,
  input  logic                     p1_lock,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p0_gnt,
  output logic                     p1_gnt,
  output logic                     p0_rvalid,
  output logic                     p1_rvalid,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     p0_stall,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);
  localparam int NP = 2;
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_e;

  state_e                               state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [NP-1:0]                        req, lock, we, gnt, cap, rvalid;
  logic [NP-1:0][ADDRESS_WIDTH-1:0]     addr;
  logic [NP-1:0][DATA_WIDTH-1:0]        wdata, rdata;
  logic                                 busy, own, cont, win_vld, win, tie;
  logic [ADDRESS_WIDTH-1:0]             mem_a_q;
  logic [DATA_WIDTH-1:0]                mem_wd_q;

  assign req   = {p1_req, p0_req};
  assign lock  = {p1_lock, p0_lock};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  assign busy = (state_q != IDLE);
  assign own  = (state_q == BUSY1);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Reset value 1 makes port 0 the winner of the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_q <= 1'b1;
    else if (win_vld) last_q <= win;
  end

  assign tie = ~last_q;
`else
  assign tie = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A locked owner keeps the memory until its burst reaches CNT_MAX; at the
  // limit a competing requester takes over, otherwise the owner carries on.
  always_comb begin
    win_vld = 1'b0;
    win     = 1'b0;
    state_d = IDLE;
    cnt_d   = '0;
    cont    = busy && req[own] && lock[own];
    if (cont && (cnt_q < CNT_MAX)) begin
      win_vld = 1'b1;
      win     = own;
    end else if (&req) begin
      win_vld = 1'b1;
      win     = cont ? ~own : tie;
    end else if (|req) begin
      win_vld = 1'b1;
      win     = req[1];
    end
    if (win_vld) begin
      state_d = win ? BUSY1 : BUSY0;
      if (cont && (win == own))
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      else
        cnt_d = CW'(1);
    end
  end

  // Address/data hold their last driven value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a_q  <= '0;
      mem_wd_q <= '0;
    end else if (busy) begin
      mem_a_q  <= addr[own];
      mem_wd_q <= wdata[own];
    end
  end

  assign mem_we = busy & we[own];
  assign mem_a  = busy ? addr[own]  : mem_a_q;
  assign mem_wd = busy ? wdata[own] : mem_wd_q;

  assign gnt[0] = (state_q == BUSY0);
  assign gnt[1] = (state_q == BUSY1);

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign cap[i] = gnt[i] & ~we[i];
    dmem_arb_rport #(.DATA_WIDTH(DATA_WIDTH)) u_rport (
      .clk      (clk),
      .rst      (rst),
      .cap_i    (cap[i]),
      .mem_rd_i (mem_rd),
      .rvalid_o (rvalid[i]),
      .rdata_o  (rdata[i])
    );
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_stall  = p0_req & ~gnt[0];
endmodule
